register_file_param: RTL and testbench

Parametrised successor to the team's 4x8 register file, with width and depth set by parameters.
- One synchronous write port and two independent registered read ports (A, B).
- Write-first bypass on same-address read/write.
- Block enable that freezes all activity.
- Multi-cycle clear sequencer with a busy flag.
- Error pulse for out-of-range and dropped accesses.
- Sits between the datapath control unit and the ALU operand muxes as the general-purpose register bank.

---
 rtl/register_file_param_pkg.sv | 16 +
 rtl/register_file_param_if.sv | 35 +++
 rtl/register_file_param_read_port.sv | 54 +++++
 rtl/register_file_param.sv | 139 +++++++++++++
 tb/tb_register_file_param.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_param_pkg.sv
// Shared types and helpers for the parametrised general-purpose register bank.
package register_file_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  // Index width for a bank of 'depth' registers; never narrower than one bit.
  function automatic int rf_addr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/register_file_param_if.sv
// Control-unit side bus of the register bank: write port, two read ports, clear and status.
interface register_file_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);

  logic              reg_on;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_a_en;
  logic [ADDR_W-1:0] rd_a_addr;
  logic [DATA_W-1:0] rd_a_data;
  logic              rd_a_valid;
  logic              rd_b_en;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [DATA_W-1:0] rd_b_data;
  logic              rd_b_valid;
  logic              clr_req;
  logic              busy;
  logic              err;

  modport master (
    output reg_on, wr_en, wr_addr, wr_data,
    output rd_a_en, rd_a_addr, rd_b_en, rd_b_addr, clr_req,
    input  rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, busy, err
  );

  modport slave (
    input  reg_on, wr_en, wr_addr, wr_data,
    input  rd_a_en, rd_a_addr, rd_b_en, rd_b_addr, clr_req,
    output rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, busy, err
  );

endinterface

// File: rtl/register_file_param_read_port.sv
// One registered read port: range check, write-first bypass, valid pulse and error term.
module rf_read_port #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_on,
  input  logic              idle,
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic              in_range;
  logic              fire;
  logic              bypass;
  logic [DATA_W-1:0] rd_next;

  assign in_range = {1'b0, rd_addr} < DEPTH_V;
  assign fire     = reg_on && idle && rd_en;
  assign bypass   = wr_fire && (wr_addr == rd_addr);
  assign rd_err   = reg_on && rd_en && !(idle && in_range);

  // wr_fire is only raised for in-range writes, so the bypass never aliases an illegal index.
  always_comb begin
    rd_next = '0;
    if (in_range) begin
      rd_next = bypass ? wr_data : mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= fire;
      if (fire) begin
        rd_data <= rd_next;
      end
    end
  end

endmodule

// File: rtl/register_file_param.sv
// Parametrised general-purpose register bank with one write port, two read ports
// and a multi-cycle clear sweep.
module register_file_param
  import register_file_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic                  clk,
  input logic                  rst,
  register_file_param_if.slave bus
);

  localparam int                ADDR_W   = rf_addr_w(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_e         state;
  rf_state_e         next_state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] next_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle;
  logic              wr_in_range;
  logic              wr_fire;
  logic              wr_err;
  logic              a_err;
  logic              b_err;
  logic              err_q;

  assign idle        = (state == IDLE);
  assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_V;
  assign wr_fire     = bus.reg_on && idle && bus.wr_en && wr_in_range;
  assign wr_err      = bus.reg_on && bus.wr_en && !(idle && wr_in_range);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  end

  // A disabled cycle leaves state and index untouched, which is what lets a paused sweep resume.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    if (bus.reg_on) begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            next_state = CLEAR;
            next_idx   = '0;
          end
        end
        CLEAR: begin
          if (idx == LAST_IDX) begin
            next_state = IDLE;
            next_idx   = '0;
          end else begin
            next_idx = idx + ADDR_W'(1);
          end
        end
        default: begin
          next_state = IDLE;
          next_idx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (wr_fire) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end else if (bus.reg_on && (state == CLEAR)) begin
      mem[idx] <= RESET_VAL;
    end
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .reg_on   (bus.reg_on),
    .idle     (idle),
    .mem      (mem),
    .wr_fire  (wr_fire),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_en    (bus.rd_a_en),
    .rd_addr  (bus.rd_a_addr),
    .rd_data  (bus.rd_a_data),
    .rd_valid (bus.rd_a_valid),
    .rd_err   (a_err)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .reg_on   (bus.reg_on),
    .idle     (idle),
    .mem      (mem),
    .wr_fire  (wr_fire),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_en    (bus.rd_b_en),
    .rd_addr  (bus.rd_b_addr),
    .rd_data  (bus.rd_b_data),
    .rd_valid (bus.rd_b_valid),
    .rd_err   (b_err)
  );

  // Every error source in a cycle collapses into a single registered pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= wr_err || a_err || b_err;
    end
  end

  assign bus.err  = err_q;
  assign bus.busy = (state == CLEAR);

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench for the register bank: a default 8x4 instance and an 8x6 instance
// with a non-zero reset value.
module tb_register_file_param;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rd_exp_t;

  logic    clk;
  logic    rst;
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  int      n_busy;
  rd_exp_t qa0[$];
  rd_exp_t qb0[$];
  rd_exp_t qa1[$];
  rd_exp_t qb1[$];
  int      qe0[$];
  int      qe1[$];
  rd_exp_t mon_e;
  int      mon_c;

  register_file_param_if #(.DATA_W(8), .ADDR_W(2)) if0 ();
  register_file_param_if #(.DATA_W(8), .ADDR_W(3)) if1 ();

  register_file_param #(.DATA_W(8), .DEPTH(4), .RESET_VAL(8'h00)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  register_file_param #(.DATA_W(8), .DEPTH(6), .RESET_VAL(8'h3C)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic check_read(input string name, input rd_exp_t e, input logic [7:0] got);
    checks++;
    if (e.cyc < 0) begin
      errors++;
      $display("[TB] FAIL %s: read pulse at cycle %0d data %h, required no pulse", name, cyc, got);
    end else if (e.cyc != cyc || e.data !== got) begin
      errors++;
      $display("[TB] FAIL %s: got data %h at cycle %0d, required %h at cycle %0d",
               name, got, cyc, e.data, e.cyc);
    end
  endtask

  task automatic check_err(input string name, input int exp_cyc);
    checks++;
    if (exp_cyc != cyc) begin
      errors++;
      $display("[TB] FAIL %s: err pulse at cycle %0d, required at cycle %0d (-1 = none)",
               name, cyc, exp_cyc);
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a read pulse or an err pulse.
  always @(negedge clk) begin
    if (if0.rd_a_valid) begin
      mon_e.cyc = -1; mon_e.data = '0;
      if (qa0.size() != 0) mon_e = qa0.pop_front();
      check_read("rd_a0", mon_e, if0.rd_a_data);
    end
    if (if0.rd_b_valid) begin
      mon_e.cyc = -1; mon_e.data = '0;
      if (qb0.size() != 0) mon_e = qb0.pop_front();
      check_read("rd_b0", mon_e, if0.rd_b_data);
    end
    if (if1.rd_a_valid) begin
      mon_e.cyc = -1; mon_e.data = '0;
      if (qa1.size() != 0) mon_e = qa1.pop_front();
      check_read("rd_a1", mon_e, if1.rd_a_data);
    end
    if (if1.rd_b_valid) begin
      mon_e.cyc = -1; mon_e.data = '0;
      if (qb1.size() != 0) mon_e = qb1.pop_front();
      check_read("rd_b1", mon_e, if1.rd_b_data);
    end
    if (if0.err) begin
      mon_c = -1;
      if (qe0.size() != 0) mon_c = qe0.pop_front();
      check_err("err0", mon_c);
    end
    if (if1.err) begin
      mon_c = -1;
      if (qe1.size() != 0) mon_c = qe1.pop_front();
      check_err("err1", mon_c);
    end
  end

  task automatic clear_strobes();
    if0.wr_en = 1'b0; if0.rd_a_en = 1'b0; if0.rd_b_en = 1'b0; if0.clr_req = 1'b0;
    if1.wr_en = 1'b0; if1.rd_a_en = 1'b0; if1.rd_b_en = 1'b0; if1.clr_req = 1'b0;
  endtask

  // Drives the prepared inputs through one rising edge and returns at the following falling edge.
  task automatic apply_stimulus();
    @(negedge clk);
    clear_strobes();
  endtask

  task automatic wr0(input logic [1:0] a, input logic [7:0] d);
    if0.wr_en = 1'b1; if0.wr_addr = a; if0.wr_data = d;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [7:0] d);
    if1.wr_en = 1'b1; if1.wr_addr = a; if1.wr_data = d;
  endtask

  task automatic rda0(input logic [1:0] a, input logic [7:0] d);
    rd_exp_t x;
    if0.rd_a_en = 1'b1; if0.rd_a_addr = a;
    x.cyc = cyc + 1; x.data = d; qa0.push_back(x);
  endtask

  task automatic rdb0(input logic [1:0] a, input logic [7:0] d);
    rd_exp_t x;
    if0.rd_b_en = 1'b1; if0.rd_b_addr = a;
    x.cyc = cyc + 1; x.data = d; qb0.push_back(x);
  endtask

  task automatic rda1(input logic [2:0] a, input logic [7:0] d);
    rd_exp_t x;
    if1.rd_a_en = 1'b1; if1.rd_a_addr = a;
    x.cyc = cyc + 1; x.data = d; qa1.push_back(x);
  endtask

  task automatic rdb1(input logic [2:0] a, input logic [7:0] d);
    rd_exp_t x;
    if1.rd_b_en = 1'b1; if1.rd_b_addr = a;
    x.cyc = cyc + 1; x.data = d; qb1.push_back(x);
  endtask

  task automatic experr0();
    qe0.push_back(cyc + 1);
  endtask

  task automatic experr1();
    qe1.push_back(cyc + 1);
  endtask

  initial begin
    rst = 1'b0;
    if0.reg_on = 1'b1; if0.wr_addr = '0; if0.wr_data = '0; if0.rd_a_addr = '0; if0.rd_b_addr = '0;
    if1.reg_on = 1'b1; if1.wr_addr = '0; if1.wr_data = '0; if1.rd_a_addr = '0; if1.rd_b_addr = '0;
    clear_strobes();
    repeat (2) @(negedge clk);
    check_output("reset_rd_a_data", if0.rd_a_data, 32'h0);
    check_output("reset_rd_b_data", if0.rd_b_data, 32'h0);
    check_output("reset_rd_a_valid", if0.rd_a_valid, 32'h0);
    check_output("reset_busy", if0.busy, 32'h0);
    check_output("reset_err", if0.err, 32'h0);
    check_output("reset_rd_a_data_1", if1.rd_a_data, 32'h0);
    rst = 1'b1;
    apply_stimulus();

    // Basic write then read, plus reset contents of reg 0.
    wr0(2'd2, 8'h18); apply_stimulus();
    rda0(2'd2, 8'h18); rdb0(2'd0, 8'h00); apply_stimulus();
    apply_stimulus();
    check_output("hold_rd_a_data", if0.rd_a_data, 32'h18);
    check_output("valid_falls", if0.rd_a_valid, 32'h0);

    // Write-first bypass on both read ports at once.
    wr0(2'd1, 8'hA5); rda0(2'd1, 8'hA5); rdb0(2'd1, 8'hA5); apply_stimulus();
    apply_stimulus();

    // Clear sweep; the read on the entry edge still completes, accesses during the sweep drop.
    wr0(2'd0, 8'h11); apply_stimulus();
    wr0(2'd1, 8'h22); apply_stimulus();
    wr0(2'd2, 8'h33); apply_stimulus();
    wr0(2'd3, 8'h44); apply_stimulus();
    if0.clr_req = 1'b1; rda0(2'd2, 8'h33); apply_stimulus();
    n_busy = 0;
    for (int i = 0; i < 8; i++) begin
      if (!if0.busy) break;
      n_busy++;
      if (i == 0) begin wr0(2'd3, 8'h77); experr0(); end
      if (i == 1) if0.clr_req = 1'b1;
      if (i == 3) begin wr0(2'd0, 8'h5A); experr0(); end
      apply_stimulus();
    end
    check_output("busy_cycles", n_busy, 32'd4);
    for (int i = 0; i < 4; i++) begin
      rda0(2'(i), 8'h00); rdb0(2'(3 - i), 8'h00); apply_stimulus();
    end

    // Sweep paused by reg_on=0 after two registers are cleared.
    wr0(2'd0, 8'h01); apply_stimulus();
    wr0(2'd1, 8'h02); apply_stimulus();
    wr0(2'd2, 8'h03); apply_stimulus();
    wr0(2'd3, 8'h04); apply_stimulus();
    rda0(2'd3, 8'h04); apply_stimulus();
    if0.clr_req = 1'b1; apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    if0.reg_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr0(2'd0, 8'hEE); if0.rd_a_en = 1'b1; if0.rd_a_addr = 2'd1;
      apply_stimulus();
      check_output("pause_busy", if0.busy, 32'h1);
      check_output("pause_rd_a_hold", if0.rd_a_data, 32'h04);
    end
    if0.reg_on = 1'b1;
    apply_stimulus();
    check_output("resume_busy_1", if0.busy, 32'h1);
    apply_stimulus();
    check_output("resume_busy_2", if0.busy, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rda0(2'(i), 8'h00); apply_stimulus();
    end

    // DEPTH=6 instance: out-of-range write and reads, top in-range register.
    wr1(3'd5, 8'h5C); apply_stimulus();
    wr1(3'd6, 8'hFF); rda1(3'd7, 8'h00); rdb1(3'd6, 8'h00); experr1(); apply_stimulus();
    for (int i = 0; i < 6; i++) begin
      rda1(3'(i), (i == 5) ? 8'h5C : 8'h3C); apply_stimulus();
    end

    // Asynchronous reset in the middle of a sweep.
    wr0(2'd1, 8'h42); apply_stimulus();
    wr0(2'd2, 8'h43); apply_stimulus();
    rda0(2'd1, 8'h42); rdb0(2'd2, 8'h43); apply_stimulus();
    if0.clr_req = 1'b1; apply_stimulus();
    apply_stimulus();
    #2 rst = 1'b0;
    #1;
    check_output("async_busy", if0.busy, 32'h0);
    check_output("async_rd_a_data", if0.rd_a_data, 32'h0);
    check_output("async_rd_b_data", if0.rd_b_data, 32'h0);
    check_output("async_rd_a_data_1", if1.rd_a_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rda1(3'(i), 8'h3C);
      if (i < 4) rda0(2'(i), 8'h00);
      apply_stimulus();
    end

    apply_stimulus();
    apply_stimulus();
    check_output("pending_expectations",
                 qa0.size() + qb0.size() + qa1.size() + qb1.size() + qe0.size() + qe1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
